// File: rtl/psum_drain_collector_if.sv
// Control and stream bundle between the PE array bottom, the drain collector and writeback.
interface psum_drain_collector_if #(
    parameter int unsigned NUM_COL = 16,
    parameter int unsigned SUM_W   = 64,
    parameter int unsigned ROW_W   = 16
);
    logic                     start;
    logic [ROW_W-1:0]         num_rows;
    logic                     in_en;
    logic [NUM_COL*SUM_W-1:0] in_sum;
    logic                     stall_req;
    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_COL*SUM_W-1:0] out_data;
    logic [ROW_W-1:0]         out_row_idx;
    logic                     busy;
    logic                     done;
    logic                     overflow;

    modport master (
        output start, num_rows, in_en, in_sum, out_ready,
        input  stall_req, out_valid, out_data, out_row_idx, busy, done, overflow
    );

    modport slave (
        input  start, num_rows, in_en, in_sum, out_ready,
        output stall_req, out_valid, out_data, out_row_idx, busy, done, overflow
    );
endinterface

// File: rtl/psum_drain_collector.sv
// De-skews the column-staggered partial-sum bus of the PE array into aligned rows,
// buffers them in a small FIFO and streams them out with their row index.
module psum_drain_collector #(
    parameter int unsigned NUM_COL    = 16,
    parameter int unsigned SUM_W      = 64,
    parameter int unsigned ARRAY_LAT  = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ROW_W      = 16
) (
    input logic                   CLK,
    input logic                   RESET,
    psum_drain_collector_if.slave bus
);
    localparam int unsigned ROW_BITS = NUM_COL * SUM_W;
    localparam int unsigned CNT_W    = ROW_W + 1;
    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FCNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] ALIGN_N = CNT_W'(ARRAY_LAT + NUM_COL - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_FLUSH
    } state_e;

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   rows_q, rows_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic [ROW_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [ROW_W-1:0]    idx_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [FCNT_W-1:0]   cnt_q, cnt_d;

    logic                cap_en;
    logic [CNT_W-1:0]    n_inc;
    logic [CNT_W-1:0]    row_off;
    logic                in_row;
    logic                last_row;
    logic                push_try;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic [SUM_W-1:0]    aligned [NUM_COL];
    logic [ROW_BITS-1:0] aligned_row;

    assign cap_en    = (state_q == ST_CAPTURE) && bus.in_en;
    assign n_inc     = n_q + CNT_W'(1);
    assign row_off   = n_inc - ALIGN_N;
    assign in_row    = (n_inc >= ALIGN_N) && (row_off < {1'b0, rows_q});
    assign last_row  = in_row && (row_off == ({1'b0, rows_q} - CNT_W'(1)));
    assign push_try  = cap_en && in_row;
    assign fifo_full = (cnt_q == FCNT_W'(FIFO_DEPTH));
    assign pop       = (cnt_q != '0) && bus.out_ready;
    // A full FIFO may still take a row when a pop frees a slot on the same edge.
    assign push      = push_try && (!fifo_full || pop);

    // Column j waits NUM_COL-1-j qualified edges so every column of a row lines up.
    for (genvar j = 0; j < NUM_COL - 1; j++) begin : g_dly
        localparam int unsigned DEPTH = NUM_COL - 1 - j;
        logic [SUM_W-1:0] sr_q [DEPTH];

        always_ff @(posedge CLK) begin
            if (RESET) begin
                for (int k = 0; k < DEPTH; k++) sr_q[k] <= '0;
            end else if (cap_en) begin
                sr_q[0] <= bus.in_sum[j*SUM_W +: SUM_W];
                for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
            end
        end

        assign aligned[j] = sr_q[DEPTH-1];
    end
    assign aligned[NUM_COL-1] = bus.in_sum[(NUM_COL-1)*SUM_W +: SUM_W];

    always_comb begin
        aligned_row = '0;
        for (int j = 0; j < NUM_COL; j++) aligned_row[j*SUM_W +: SUM_W] = aligned[j];
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + FCNT_W'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - FCNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_q[k] <= '0;
                idx_q[k] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= aligned_row;
                idx_q[wr_ptr_q] <= row_off[ROW_W-1:0];
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    // Job sequencing; done fires on the edge that leaves the FIFO empty in FLUSH.
    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        n_d     = n_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q | (push_try && fifo_full && !pop);
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    rows_d  = bus.num_rows;
                    n_d     = '0;
                    state_d = (bus.num_rows == '0) ? ST_FLUSH : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (cap_en) begin
                    n_d = n_inc;
                    if (last_row) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (cnt_d == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            rows_q  <= '0;
            n_q     <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            n_q     <= n_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.stall_req   = fifo_full;
    assign bus.out_valid   = (cnt_q != '0);
    assign bus.out_data    = mem_q[rd_ptr_q];
    assign bus.out_row_idx = idx_q[rd_ptr_q];
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: doc/psum_drain_collector.md
Name: psum_drain_collector

Overview:
- Output-side partner of the weight-stationary PE array. Consumes the skewed per-column partial-sum bus from the bottom of the array.
- Column j of result row r arrives j cycles after column 0. The block de-skews each row into a single aligned row and buffers it in a small FIFO.
- Rows are delivered on a valid/ready stream to the writeback logic, with row index.
- Drives a stall request back to the array enable, so results are never lost.

Parameters:
- NUM_COL, 16, PE columns, i.e. number of sums per row.
- SUM_W, 64, width of one partial sum.
- ARRAY_LAT, 16, qualified cycles from start to row 0 / column 0 being on in_sum.
- FIFO_DEPTH, 4, aligned-row FIFO entries (power of 2, ≥2).
- ROW_W, 16, width of the row count and row index.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a drain job; ignored unless idle.
- num_rows  in  ROW_W  rows in the job; latched on an accepted start.
- in_en  in  1  array enable as actually applied; all capture and counting advance only when 1.
- in_sum  in  NUM_COL*SUM_W  bottom-of-array sums; column j at bits [(j+1)*SUM_W-1 : j*SUM_W].
- stall_req  out  1  = FIFO full (combinational); the array enable must be gated with ~stall_req.
- out_valid  out  1  aligned row available.
- out_ready  in  1  consumer accepts the row when out_valid & out_ready.
- out_data  out  NUM_COL*SUM_W  aligned row, same column packing as in_sum.
- out_row_idx  out  ROW_W  row number of out_data.
- busy  out  1  job in progress (not IDLE).
- done  out  1  one-cycle pulse when the last row has been accepted downstream.
- overflow  out  1  sticky error flag; cleared only by RESET.

Behaviour:
- Reset: RESET=1 at an edge forces the following, regardless of state:
  - State to IDLE; FIFO emptied; delay lines zeroed; counters zeroed.
  - out_valid=0, out_data=0, out_row_idx=0, busy=0, done=0, overflow=0.
  - A job in flight is discarded.
- States: IDLE → CAPTURE → FLUSH → IDLE.
- IDLE:
  - start=1 latches num_rows, clears the qualified-edge counter n, and sets busy=1 from the next cycle.
  - If num_rows=0: go to FLUSH (FIFO is empty), so done pulses exactly 2 cycles after start.
  - Otherwise go to CAPTURE.
- CAPTURE: each edge with in_en=1 increments n (first qualified edge after start is n=1) and samples in_sum.
  - For column j the sample belongs to row r = n − ARRAY_LAT − j; it is valid when 0 ≤ r < num_rows.
  - Column j passes through a delay line of NUM_COL−1−j qualified stages (column NUM_COL−1 has none).
  - Row r becomes aligned at qualified edge n = ARRAY_LAT + r + NUM_COL − 1 and is pushed into the FIFO at that edge with index r.
  - After the push of row num_rows−1, go to FLUSH.
  - Edges with in_en=0: no sampling, no shifting, n holds.
- FLUSH: wait until the FIFO is empty and no handshake is pending, then pulse done for 1 cycle, clear busy, and return to IDLE in the same cycle as done.
- start while busy: ignored, no effect.
- FIFO:
  - A push makes out_valid visible the next cycle (latency 1 edge from alignment).
  - out_data and out_row_idx are stable while out_valid & ~out_ready.
  - Push and pop in the same cycle when full is legal; count is unchanged and stall_req stays 1 that cycle.
  - Pop when empty: impossible, since out_valid=0.
- Overflow: a push attempted while full with in_en=1 (i.e. the enable was not gated) drops the row and sets overflow=1.
- Arithmetic: pure data movement. No sign or width change; sums pass bit-exact.
- Counter n is ROW_W+1 bits wide. This covers num_rows + ARRAY_LAT + NUM_COL with no wrap for a legal num_rows.

Test Plan (NUM_COL=4, ARRAY_LAT=2, FIFO_DEPTH=4, SUM_W=64 unless noted):
- Basic drain:
  - Stimulus: start with num_rows=3, in_en=1 always, out_ready=1; drive in_sum column j at edge n with value 100*r+j for r = n−2−j.
  - Required: rows 0,1,2 out at edges 6,7,8 (out_valid the cycle after n=5,6,7) with data {3,2,1,0}+100r and idx 0,1,2; done one cycle after the last accept; busy low afterwards.
- Back-pressure:
  - Stimulus: same job with num_rows=8, out_ready=0, in_en = ~stall_req.
  - Required: stall_req rises after 4 pushes; n freezes; overflow stays 0; releasing out_ready drains all 8 rows in order, bit-exact, idx 0..7.
- Enable bubbles: insert in_en=0 for 3 cycles mid-capture → identical output data and order as the basic drain, shifted by 3 cycles.
- Overflow:
  - Stimulus: out_ready=0 with in_en forced to 1 and num_rows=6.
  - Required: rows 0–3 are buffered; rows 4 and 5 are dropped; overflow=1 and stays 1 until RESET.
- Edge cases:
  - num_rows=0: done pulses 2 cycles after start with no out_valid.
  - start pulsed during busy: ignored; only one done.
- Reset mid-job: assert RESET during CAPTURE with 2 rows in the FIFO → next cycle out_valid=0, busy=0, overflow=0; a fresh start then behaves exactly as the basic drain.
